// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg: shared MDU op and state encodings                      rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package cpu_pkg;

  localparam logic [2:0] MDU_MULT  = 3'd0;
  localparam logic [2:0] MDU_MULTU = 3'd1;
  localparam logic [2:0] MDU_DIV   = 3'd2;
  localparam logic [2:0] MDU_DIVU  = 3'd3;
  localparam logic [2:0] MDU_MTHI  = 3'd4;
  localparam logic [2:0] MDU_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_RUN  = 2'd1,
    MDU_FIX  = 2'd2
  } mdu_state_e;

  function automatic logic mdu_op_signed(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

  function automatic logic mdu_op_div(input logic [2:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_divstep.sv
// ---------------------------------------------------------------------------
// mdu_divstep: combinational BPC-bit restoring divide step (MDU_DIV_EN) rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mdu_divstep
  import cpu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int BPC   = 1
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] dvd_i,
  input  logic [WIDTH-1:0] dvsr_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] dvd_o
);

  logic [WIDTH:0]   w_trial;
  logic [WIDTH-1:0] w_rem;
  logic [WIDTH-1:0] w_dvd;

  // Dividend bits leave the top of dvd while quotient bits enter at the bottom.
  always_comb begin
    w_rem   = rem_i;
    w_dvd   = dvd_i;
    w_trial = '0;
    for (int i = 0; i < BPC; i++) begin
      w_trial = {w_rem, w_dvd[WIDTH-1]};
      w_dvd   = {w_dvd[WIDTH-2:0], 1'b0};
      if (w_trial >= {1'b0, dvsr_i}) begin
        w_trial  = w_trial - {1'b0, dvsr_i};
        w_dvd[0] = 1'b1;
      end
      w_rem = w_trial[WIDTH-1:0];
    end
  end

  assign rem_o = w_rem;
  assign dvd_o = w_dvd;

endmodule

`default_nettype wire

// File: rtl/mdu_iter.sv
// ---------------------------------------------------------------------------
// mdu_iter: iterative multiply/divide unit with HI/LO; divider under MDU_DIV_EN
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mdu_iter
  import cpu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int BPC   = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             dword,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int                 C_CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [C_CNT_W-1:0] C_CNT_32   = C_CNT_W'(32 / BPC);
  localparam logic [C_CNT_W-1:0] C_CNT_FULL = C_CNT_W'(WIDTH / BPC);
  localparam logic [WIDTH-1:0]   C_MASK32   = WIDTH'({32{1'b1}});
`ifdef MDU_DIV_EN
  localparam bit                 C_DIV_EN   = 1'b1;
`else
  localparam bit                 C_DIV_EN   = 1'b0;
`endif

  mdu_state_e           state_q;
  logic [C_CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]     opa_q;
  logic [WIDTH-1:0]     opb_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]     hi_q;
  logic [WIDTH-1:0]     lo_q;
  logic                 is_div_q;
  logic                 n32_q;
  logic                 neg_res_q;
  logic                 neg_rem_q;
  logic                 dvz_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 illegal_q;

  logic                 w_n32;
  logic [WIDTH-1:0]     w_mask;
  logic [WIDTH-1:0]     w_a_n;
  logic [WIDTH-1:0]     w_b_n;
  logic                 w_a_neg;
  logic                 w_b_neg;
  logic [WIDTH-1:0]     w_a_mag;
  logic [WIDTH-1:0]     w_b_mag;
  logic                 w_mdop;

  // 32-bit ops also apply when WIDTH is 32, whatever dword says.
  assign w_n32   = !dword || (WIDTH == 32);
  assign w_mask  = w_n32 ? C_MASK32 : '1;
  assign w_a_n   = a & w_mask;
  assign w_b_n   = b & w_mask;
  assign w_a_neg = mdu_op_signed(op) && (w_n32 ? a[31] : a[WIDTH-1]);
  assign w_b_neg = mdu_op_signed(op) && (w_n32 ? b[31] : b[WIDTH-1]);
  assign w_a_mag = w_a_neg ? ((-w_a_n) & w_mask) : w_a_n;
  assign w_b_mag = w_b_neg ? ((-w_b_n) & w_mask) : w_b_n;
  assign w_mdop  = (op == MDU_MULT) || (op == MDU_MULTU) || (C_DIV_EN && mdu_op_div(op));

  // MSB-first shift-add: acc = acc * 2^BPC + multiplicand * digit.
  logic [BPC-1:0]     w_digit;
  logic [2*WIDTH-1:0] w_mul_acc;

  assign w_digit = opa_q[WIDTH-1 -: BPC];

  always_comb begin
    w_mul_acc = acc_q << BPC;
    for (int j = 0; j < BPC; j++) begin
      if (w_digit[j]) begin
        w_mul_acc = w_mul_acc + ({{WIDTH{1'b0}}, opb_q} << j);
      end
    end
  end

  logic [WIDTH-1:0] w_div_rem;
  logic [WIDTH-1:0] w_div_dvd;

`ifdef MDU_DIV_EN
  mdu_divstep #(
    .WIDTH (WIDTH),
    .BPC   (BPC)
  ) u_divstep (
    .rem_i  (acc_q[WIDTH-1:0]),
    .dvd_i  (opa_q),
    .dvsr_i (opb_q),
    .rem_o  (w_div_rem),
    .dvd_o  (w_div_dvd)
  );
`else
  assign w_div_rem = '0;
  assign w_div_dvd = '0;
`endif

  function automatic logic [WIDTH-1:0] sext32(input logic [WIDTH-1:0] x);
    return x[31] ? (x | ~C_MASK32) : (x & C_MASK32);
  endfunction

  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_res_hi;
  logic [WIDTH-1:0]   w_res_lo;

  // Sign fix-up; most-negative / -1 wraps back to most-negative naturally.
  always_comb begin
    w_prod = neg_res_q ? -acc_q : acc_q;
    w_quo  = neg_res_q ? -opa_q : opa_q;
    w_rem  = neg_rem_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    if (dvz_q) begin
      w_quo = '1;
    end
    if (is_div_q) begin
      w_res_hi = w_rem;
      w_res_lo = w_quo;
    end else if (n32_q) begin
      w_res_hi = WIDTH'(w_prod[63:32]);
      w_res_lo = w_prod[WIDTH-1:0];
    end else begin
      w_res_hi = w_prod[2*WIDTH-1:WIDTH];
      w_res_lo = w_prod[WIDTH-1:0];
    end
    if (n32_q) begin
      w_res_hi = sext32(w_res_hi);
      w_res_lo = sext32(w_res_lo);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= MDU_IDLE;
      cnt_q     <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      acc_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_div_q  <= 1'b0;
      n32_q     <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dvz_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      unique case (state_q)
        MDU_IDLE: begin
          if (start && !abort) begin
            if (w_mdop) begin
              state_q   <= MDU_RUN;
              busy_q    <= 1'b1;
              cnt_q     <= w_n32 ? C_CNT_32 : C_CNT_FULL;
              // Top-align the shifted operand so N-bit ops finish in N/BPC steps.
              opa_q     <= w_n32 ? (w_a_mag << (WIDTH - 32)) : w_a_mag;
              opb_q     <= w_b_mag;
              acc_q     <= '0;
              is_div_q  <= mdu_op_div(op);
              n32_q     <= w_n32;
              neg_res_q <= w_a_neg ^ w_b_neg;
              neg_rem_q <= w_a_neg;
              dvz_q     <= mdu_op_div(op) && (w_b_n == '0);
            end else if (op == MDU_MTHI) begin
              hi_q <= a;
            end else if (op == MDU_MTLO) begin
              lo_q <= a;
            end else begin
              illegal_q <= 1'b1;
            end
          end
        end
        MDU_RUN: begin
          if (abort) begin
            state_q <= MDU_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - C_CNT_W'(1);
            if (cnt_q == C_CNT_W'(1)) begin
              state_q <= MDU_FIX;
            end
            if (is_div_q) begin
              acc_q <= {{WIDTH{1'b0}}, w_div_rem};
              opa_q <= w_div_dvd;
            end else begin
              acc_q <= w_mul_acc;
              opa_q <= opa_q << BPC;
            end
          end
        end
        MDU_FIX: begin
          state_q <= MDU_IDLE;
          busy_q  <= 1'b0;
          if (!abort) begin
            hi_q   <= w_res_hi;
            lo_q   <= w_res_lo;
            done_q <= 1'b1;
          end
        end
        default: begin
          state_q <= MDU_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign illegal = illegal_q;
  assign hi      = hi_q;
  assign lo      = lo_q;

endmodule

`default_nettype wire

// File: doc/mdu_iter.md
MDU_ITER -- requirements
Module: mdu_iter

Interface
REQ-001 Parameter WIDTH, default 64: datapath and HI/LO width; legal values 32 or 64.
REQ-002 Parameter BPC, default 1: quotient or multiplier bits retired per cycle; legal values 1, 2, 4.
REQ-003 Clock and reset: one clock `clk`; reset `rstn` is asynchronous and active-low.
REQ-004 Port list, one per line:
- clk  in  1  clock, rising edge.
- rstn  in  1  async active-low reset.
- start  in  1  begin the operation in op.
- op  in  3  operation: 0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; 6 and 7 are reserved.
- dword  in  1  1 = WIDTH-bit op; 0 = 32-bit op on a[31:0] and b[31:0].
- a  in  WIDTH  multiplicand, dividend, or MTHI/MTLO data.
- b  in  WIDTH  multiplier or divisor.
- abort  in  1  flush the in-flight op, e.g. on an exception.
- busy  out  1  op in progress; pipeline stalls MFHI/MFLO while high.
- done  out  1  one-cycle pulse; HI/LO updated this cycle.
- illegal  out  1  one-cycle pulse on a reserved or compiled-out op.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Function
REQ-005 States: IDLE, RUN, FIX.
REQ-006 IDLE with start=1 and op MULT..DIVU: latch operands into IDLE->RUN; iteration counter = N/BPC, where N = WIDTH if dword else 32.
REQ-007 Operand formation when dword=0: low 32 bits only; signed ops sign-extend from bit 31, unsigned ops zero-extend; dword=1 with WIDTH=32 is treated as dword=0.
REQ-008 Signed ops run on magnitudes; in FIX, negate the product, or the quotient, if operand signs differ; the remainder takes the dividend's sign.
REQ-009 Multiply: shift-add, BPC bits per cycle, 2N-bit product; hi = upper N bits, lo = lower N bits.
REQ-010 Divide: restoring, BPC quotient bits per cycle; lo = quotient, hi = remainder.
REQ-011 Divide by zero: no fault; hi = dividend, lo = all ones (N bits).
REQ-012 Signed overflow (most-negative / -1): lo = most-negative, hi = 0.
REQ-013 32-bit results: hi and lo are each sign-extended from bit 31 to WIDTH, including MULTU and DIVU.
REQ-014 RUN: decrement the counter once per cycle; at zero go to FIX; FIX returns to IDLE.
REQ-015 Latency: done, together with the new hi/lo values, appears exactly N/BPC+1 cycles after the start edge.
- Example: 33 cycles for a 32-bit op at BPC=1.
REQ-016 busy = 1 in RUN and FIX, 0 in IDLE; hi/lo hold their values until done.
REQ-017 start while busy is ignored; no queueing.
REQ-018 MTHI/MTLO in IDLE: write a (full WIDTH) to hi or lo at the next edge; busy stays 0; done stays 0.
REQ-019 abort in RUN or FIX: state goes to IDLE at the next edge; hi/lo unchanged; no done pulse.
REQ-020 abort in IDLE: suppresses a simultaneous start, including MTHI/MTLO.
REQ-021 Reserved op with start in IDLE: pulse illegal next cycle; no state change.

Reset
REQ-022 Reset values while rstn=0, asynchronously:
- state IDLE;
- hi = 0, lo = 0;
- busy = 0, done = 0, illegal = 0;
- counter and operand registers = 0.
REQ-023 Reset mid-operation: the op is discarded; no done pulse after reset release.

Configuration
REQ-024 Macro MDU_DIV_EN defined: divider compiled in; DIV and DIVU behave per REQ-010..REQ-012.
REQ-025 Macro MDU_DIV_EN undefined: no divider logic; DIV and DIVU are treated as reserved per REQ-021.

Structure
REQ-026 Shared package cpu_pkg: op encodings (MDU_MULT..MDU_MTLO) and state encodings; DECODE fills op from the instruction.
REQ-027 One sub-module, mdu_divstep: combinational BPC-bit restoring divide step, instantiated only under MDU_DIV_EN.

Verification
REQ-028 WIDTH=64, BPC=1; MULT, dword=0, a=-3, b=7 -> after 33 cycles done=1, lo=0xFFFFFFFFFFFFFFEB, hi=0xFFFFFFFFFFFFFFFF.
REQ-029 DMULTU, i.e. MULTU with dword=1, a=0x8000000000000000, b=4 -> after 65 cycles hi=2, lo=0.
REQ-030 DIV, dword=0, a=-7, b=2 -> lo=-3 (sign-extended), hi=-1; with BPC=4, done after 9 cycles.
REQ-031 DIVU, dword=0, a=5, b=0 -> hi=5, lo=0xFFFFFFFFFFFFFFFF; with MDU_DIV_EN undefined -> illegal pulse, busy stays 0.
REQ-032 MTLO a=0x1234 -> lo=0x1234 at the next edge; then MULT with abort at cycle 10 -> busy=0 next cycle, lo still 0x1234, no done.
REQ-033 rstn low in cycle 5 of a DIV -> all outputs 0 immediately; no done after release; a start issued after release completes normally.
